// File: rtl/inst_stream_loader.sv
// Boot loader: packs a UART byte stream into instruction words and writes them to
// instruction memory, framed by a 32-bit length header or a terminator word.
module inst_stream_loader #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned BIG_ENDIAN = 1,
    parameter int unsigned MODE       = 0,
    parameter logic [8*WORD_BYTES-1:0] TERM_WORD = '0
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    start,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W:0]         words_loaded,
    output logic                    err_overflow
);

    localparam int unsigned W = 8 * WORD_BYTES;
    localparam logic [ADDR_W:0] DepthL = (ADDR_W + 1)'(DEPTH);
    localparam logic [2:0] LastByte = 3'(WORD_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StHdr, StData, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       hdr_q, hdr_d;
    logic [W-1:0]      word_q, word_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              err_q, err_d;

    logic [W+7:0] cat_be, cat_le;
    logic [W-1:0] word_next;
    logic [31:0]  hdr_next;
    logic         word_done, last_written;

    assign cat_be    = {word_q, rx_data};
    assign cat_le    = {rx_data, word_q};
    assign word_next = (BIG_ENDIAN != 0) ? cat_be[W-1:0] : cat_le[W+7:8];
    assign hdr_next  = {hdr_q[23:0], rx_data};
    assign word_done = (byte_cnt_q == LastByte);
    // words_q is already post-increment while the final write is on the port
    assign last_written = mem_we_q && (words_q == count_q);

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        hdr_d       = hdr_q;
        word_d      = word_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        words_d     = words_q;
        err_d       = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    words_d    = '0;
                    err_d      = 1'b0;
                    byte_cnt_d = '0;
                    state_d    = (MODE == 0) ? StHdr : StData;
                end
            end
            StHdr: begin
                if (!start) begin
                    state_d = StIdle;
                end else if (rx_valid) begin
                    hdr_d      = hdr_next;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd3) begin
                        byte_cnt_d = '0;
                        if (hdr_next == 32'd0) begin
                            state_d = StDone;
                        end else if (hdr_next > 32'(DEPTH)) begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end else begin
                            count_d = hdr_next[ADDR_W:0];
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (!start) begin
                    state_d = StIdle;
                end else if (MODE == 0 && last_written) begin
                    state_d = StDone;
                end else if (rx_valid) begin
                    word_d     = word_next;
                    byte_cnt_d = word_done ? 3'd0 : byte_cnt_q + 3'd1;
                    if (word_done) begin
                        if (MODE != 0 && word_next == TERM_WORD) begin
                            state_d = StDone;
                        end else if (words_q >= DepthL) begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end else begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = words_q[ADDR_W-1:0];
                            mem_wdata_d = word_next;
                            words_d     = words_q + 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                if (!start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            hdr_q       <= '0;
            word_q      <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            words_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            hdr_q       <= hdr_d;
            word_q      <= word_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            words_q     <= words_d;
            err_q       <= err_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = (state_q == StHdr) || (state_q == StData);
    assign done         = (state_q == StDone);
    assign words_loaded = words_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_inst_stream_loader.sv
// Scoreboard bench: four loader configurations share the byte stream, each with its own start.
module tb_inst_stream_loader;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [3:0]  start = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [3:0]  we, busy, done, err;
    logic [9:0]  addr [4];
    logic [10:0] wl [4];
    logic [31:0] wd0, wd2, wd3;
    logic [15:0] wd1;

    always #5 CLK = ~CLK;

    // dut0: length header, big-endian 32-bit words
    inst_stream_loader #(.WORD_BYTES(4), .DEPTH(1024), .ADDR_W(10), .BIG_ENDIAN(1), .MODE(0))
        u0 (.CLK(CLK), .RSTN(RSTN), .start(start[0]), .rx_data(rx_data), .rx_valid(rx_valid),
            .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wd0), .busy(busy[0]),
            .done(done[0]), .words_loaded(wl[0]), .err_overflow(err[0]));
    // dut1: little-endian 16-bit words
    inst_stream_loader #(.WORD_BYTES(2), .DEPTH(1024), .ADDR_W(10), .BIG_ENDIAN(0), .MODE(0))
        u1 (.CLK(CLK), .RSTN(RSTN), .start(start[1]), .rx_data(rx_data), .rx_valid(rx_valid),
            .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wd1), .busy(busy[1]),
            .done(done[1]), .words_loaded(wl[1]), .err_overflow(err[1]));
    // dut2: tiny memory for header overflow
    inst_stream_loader #(.WORD_BYTES(4), .DEPTH(4), .ADDR_W(10), .BIG_ENDIAN(1), .MODE(0))
        u2 (.CLK(CLK), .RSTN(RSTN), .start(start[2]), .rx_data(rx_data), .rx_valid(rx_valid),
            .mem_we(we[2]), .mem_addr(addr[2]), .mem_wdata(wd2), .busy(busy[2]),
            .done(done[2]), .words_loaded(wl[2]), .err_overflow(err[2]));
    // dut3: terminator framing, zero terminator, two-word memory
    inst_stream_loader #(.WORD_BYTES(4), .DEPTH(2), .ADDR_W(10), .BIG_ENDIAN(1), .MODE(1),
                         .TERM_WORD(32'h0))
        u3 (.CLK(CLK), .RSTN(RSTN), .start(start[3]), .rx_data(rx_data), .rx_valid(rx_valid),
            .mem_we(we[3]), .mem_addr(addr[3]), .mem_wdata(wd3), .busy(busy[3]),
            .done(done[3]), .words_loaded(wl[3]), .err_overflow(err[3]));

    typedef struct {
        int unsigned addr;
        logic [63:0] data;
    } wr_t;

    wr_t expq [4][$];
    int  n_vec = 0;
    int  n_err = 0;

    function automatic logic [63:0] wdata_of(int i);
        case (i)
            0:       return 64'(wd0);
            1:       return 64'(wd1);
            2:       return 64'(wd2);
            default: return 64'(wd3);
        endcase
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(int i, int unsigned a, logic [63:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        expq[i].push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send4(logic [31:0] w);
        for (int k = 3; k >= 0; k--) send(w[8*k +: 8]);
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 4; i++) begin
                if (we[i] === 1'b1) begin
                    if (expq[i].size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_write dut%0d: got addr %0h data %0h, required none",
                                 i, addr[i], wdata_of(i));
                    end else begin
                        e = expq[i].pop_front();
                        chk($sformatf("wr_addr dut%0d", i), 64'(addr[i]), 64'(e.addr));
                        chk($sformatf("wr_data dut%0d", i), wdata_of(i), e.data);
                    end
                end
            end
        end
    endtask

    initial begin
        // reset with noise on the byte strobe
        repeat (2) begin
            @(posedge CLK);
            #1;
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
        end
        tick();
        rx_valid = 1'b0;
        RSTN = 1'b1;
        fork
            monitor();
        join_none
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_we dut%0d", i), 64'(we[i]), 64'd0);
            chk($sformatf("rst_busy dut%0d", i), 64'(busy[i]), 64'd0);
            chk($sformatf("rst_done dut%0d", i), 64'(done[i]), 64'd0);
            chk($sformatf("rst_err dut%0d", i), 64'(err[i]), 64'd0);
            chk($sformatf("rst_wl dut%0d", i), 64'(wl[i]), 64'd0);
            chk($sformatf("rst_addr dut%0d", i), 64'(addr[i]), 64'd0);
            chk($sformatf("rst_wdata dut%0d", i), wdata_of(i), 64'd0);
        end
        // bytes in IDLE must never be written
        send4(32'h0000_0001);
        send4(32'hCAFE_F00D);
        tick();
        chk("idle_wl dut0", 64'(wl[0]), 64'd0);

        // dut0: two big-endian words
        start[0] = 1'b1;
        tick();
        chk("hdr_busy dut0", 64'(busy[0]), 64'd1);
        send4(32'h0000_0002);
        push(0, 0, 64'hDEAD_BEEF);
        send4(32'hDEAD_BEEF);
        chk("we_latency dut0", 64'(we[0]), 64'd1);
        push(0, 1, 64'h0102_0304);
        send4(32'h0102_0304);
        chk("last_we dut0", 64'(we[0]), 64'd1);
        chk("last_wl dut0", 64'(wl[0]), 64'd2);
        chk("early_done dut0", 64'(done[0]), 64'd0);
        tick();
        chk("done dut0", 64'(done[0]), 64'd1);
        chk("done_busy dut0", 64'(busy[0]), 64'd0);
        start[0] = 1'b0;
        tick();
        chk("idle_done dut0", 64'(done[0]), 64'd0);
        chk("hold_wl dut0", 64'(wl[0]), 64'd2);

        // dut0: zero-length header
        start[0] = 1'b1;
        tick();
        send4(32'h0000_0000);
        chk("zero_done dut0", 64'(done[0]), 64'd1);
        chk("zero_wl dut0", 64'(wl[0]), 64'd0);
        start[0] = 1'b0;
        tick();

        // dut0: abort after six data bytes, then restart from address 0
        start[0] = 1'b1;
        tick();
        send4(32'h0000_0003);
        push(0, 0, 64'hA1A2_A3A4);
        send4(32'hA1A2_A3A4);
        send(8'hB1);
        send(8'hB2);
        start[0] = 1'b0;
        tick();
        chk("abort_busy dut0", 64'(busy[0]), 64'd0);
        chk("abort_done dut0", 64'(done[0]), 64'd0);
        chk("abort_wl dut0", 64'(wl[0]), 64'd1);
        tick();
        start[0] = 1'b1;
        tick();
        chk("restart_wl dut0", 64'(wl[0]), 64'd0);
        send4(32'h0000_0001);
        push(0, 0, 64'hC0C1_C2C3);
        send4(32'hC0C1_C2C3);
        tick();
        chk("restart_done dut0", 64'(done[0]), 64'd1);
        chk("restart_wl1 dut0", 64'(wl[0]), 64'd1);
        start[0] = 1'b0;
        tick();

        // dut1: little-endian 16-bit words, back-to-back bytes
        start[1] = 1'b1;
        tick();
        send4(32'h0000_0002);
        push(1, 0, 64'h1234);
        send(8'h34);
        send(8'h12);
        push(1, 1, 64'h5678);
        send(8'h78);
        send(8'h56);
        tick();
        chk("done dut1", 64'(done[1]), 64'd1);
        chk("wl dut1", 64'(wl[1]), 64'd2);
        start[1] = 1'b0;
        tick();

        // dut2: header larger than memory
        start[2] = 1'b1;
        tick();
        send4(32'h0000_0005);
        chk("ovf_err dut2", 64'(err[2]), 64'd1);
        chk("ovf_done dut2", 64'(done[2]), 64'd1);
        chk("ovf_wl dut2", 64'(wl[2]), 64'd0);
        send4(32'h1111_2222);
        start[2] = 1'b0;
        tick();
        chk("ovf_hold dut2", 64'(err[2]), 64'd1);
        start[2] = 1'b1;
        tick();
        chk("ovf_clear dut2", 64'(err[2]), 64'd0);
        start[2] = 1'b0;
        tick();

        // dut3: terminator framing
        start[3] = 1'b1;
        tick();
        push(3, 0, 64'h1122_3344);
        send4(32'h1122_3344);
        send4(32'h0000_0000);
        chk("term_done dut3", 64'(done[3]), 64'd1);
        chk("term_wl dut3", 64'(wl[3]), 64'd1);
        chk("term_err dut3", 64'(err[3]), 64'd0);
        start[3] = 1'b0;
        tick();
        start[3] = 1'b1;
        tick();
        push(3, 0, 64'h0102_0304);
        send4(32'h0102_0304);
        push(3, 1, 64'h0506_0708);
        send4(32'h0506_0708);
        send4(32'h090A_0B0C);
        chk("tovf_err dut3", 64'(err[3]), 64'd1);
        chk("tovf_done dut3", 64'(done[3]), 64'd1);
        chk("tovf_wl dut3", 64'(wl[3]), 64'd2);
        start[3] = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 4; i++)
            chk($sformatf("missing_writes dut%0d", i), 64'(expq[i].size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
